// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweeper.
// Imported by the sweeper top and its settle timer.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam int N_IN_DEF   = 3;
  localparam int SETTLE_DEF = 1;

endpackage

// File: rtl/settle_timer.sv
// Counts enabled cycles and pulses expire on the SETTLE-th one.
// Cleared between vectors so a single instance serves the whole sweep.
module settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a single-output FUT, captures
// its truth table and compares it against a latched expectation.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF,
  localparam int V     = 1 << N_IN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [V-1:0]    expected,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic [V-1:0]    minterms,
  output logic [N_IN:0]   ones_count,
  output logic            match,
  output logic [N_IN-1:0] first_fail
);

  state_t state;
  state_t nxt;

  logic [N_IN:0]   index;
  logic [V-1:0]    exp_q;
  logic [V-1:0]    min_nxt;
  logic [V-1:0]    diff;
  logic [N_IN-1:0] ff_nxt;
  logic            last;
  logic            tmr_clr;
  logic            tmr_en;
  logic            expire;

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clr),
    .en    (tmr_en),
    .expire(expire)
  );

  assign last   = (index == (N_IN + 1)'(V - 1));
  assign dut_in = index[N_IN-1:0];
  assign busy   = (state == DRIVE) || (state == SAMPLE);
  assign done   = (state == DONE);

  always_comb begin
    nxt     = state;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt     = DRIVE;
          tmr_clr = 1'b1;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (expire) nxt = SAMPLE;
      end
      SAMPLE: begin
        tmr_clr = 1'b1;
        nxt     = last ? DONE : DRIVE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Compare on the table including the bit being captured now,
  // so match/first_fail are already valid in the DONE cycle.
  always_comb begin
    min_nxt = minterms;
    min_nxt[index[N_IN-1:0]] = dut_out;
    diff   = min_nxt ^ exp_q;
    ff_nxt = '0;
    for (int i = V - 1; i >= 0; i--) begin
      if (diff[i]) ff_nxt = N_IN'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      exp_q      <= '0;
      minterms   <= '0;
      ones_count <= '0;
      match      <= 1'b0;
      first_fail <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_q      <= expected;
            minterms   <= '0;
            ones_count <= '0;
            index      <= '0;
          end
        end
        SAMPLE: begin
          minterms   <= min_nxt;
          ones_count <= ones_count + (N_IN + 1)'(dut_out);
          if (last) begin
            match      <= (min_nxt == exp_q);
            first_fail <= ff_nxt;
          end else begin
            index <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a cycle model of
// the SETTLE=1 instance and two delayed-FUT instances.
module tb_truth_table_sweeper;

  localparam int V  = 8;
  localparam int S0 = 1;
  localparam int L  = V * (S0 + 1);

  logic clk;
  logic reset;
  logic start0, start1, start2;
  logic [7:0] expected0, expected1, expected2;
  logic dut_out0, dut_out1, dut_out2;
  logic [2:0] dut_in0, dut_in1, dut_in2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic [7:0] min0, min1, min2;
  logic [3:0] ones0, ones1, ones2;
  logic match0, match1, match2;
  logic [2:0] ff0, ff1, ff2;

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  bit chk_en = 0;

  function automatic logic fut(logic [2:0] x);
    return (~x[2] | x[1]) & (x[1] | ~x[0]);
  endfunction

  assign dut_out0 = (mode == 1) ? 1'b1 :
                    (mode == 2) ? 1'b0 : fut(dut_in0);

  logic p1a, p1b, p2a, p2b;
  always @(posedge clk) begin
    p1a <= fut(dut_in1);
    p1b <= p1a;
    p2a <= fut(dut_in2);
    p2b <= p2a;
  end
  assign dut_out1 = p1b;
  assign dut_out2 = p2b;

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .expected(expected0), .dut_out(dut_out0),
    .dut_in(dut_in0), .busy(busy0), .done(done0),
    .minterms(min0), .ones_count(ones0),
    .match(match0), .first_fail(ff0)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .expected(expected1), .dut_out(dut_out1),
    .dut_in(dut_in1), .busy(busy1), .done(done1),
    .minterms(min1), .ones_count(ones1),
    .match(match1), .first_fail(ff1)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u2 (
    .clk(clk), .reset(reset), .start(start2),
    .expected(expected2), .dut_out(dut_out2),
    .dut_in(dut_in2), .busy(busy2), .done(done2),
    .minterms(min2), .ones_count(ones2),
    .match(match2), .first_fail(ff2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tt_of(int md);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      int a, b, c;
      a = (i >> 2) & 1;
      b = (i >> 1) & 1;
      c = i & 1;
      if (md == 1) t[i] = 1'b1;
      else if (md == 2) t[i] = 1'b0;
      else t[i] = ((((1 - a) | b) & (b | (1 - c))) != 0);
    end
    return t;
  endfunction

  function automatic int low_bit(logic [7:0] d);
    int r;
    r = 0;
    for (int i = 7; i >= 0; i--) if (d[i]) r = i;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: sweep phase counter plus results held between sweeps
  int ph;
  logic [7:0] lat, mmin;
  int mones;
  logic mmatch;
  int mff, mdin;

  always @(posedge clk) begin
    if (reset) begin
      ph <= 0; lat <= '0; mmin <= '0; mones <= 0;
      mmatch <= 1'b0; mff <= 0; mdin <= 0;
    end else if (ph == 0) begin
      if (start0) begin
        ph <= 1; lat <= expected0;
        mmin <= '0; mones <= 0; mdin <= 0;
      end
    end else if (ph < L) begin
      ph <= ph + 1;
    end else if (ph == L) begin
      ph <= L + 1;
      mmin <= tt_of(mode);
      mones <= $countones(tt_of(mode));
      mmatch <= (tt_of(mode) == lat);
      mff <= low_bit(tt_of(mode) ^ lat);
      mdin <= V - 1;
    end else begin
      ph <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (ph >= 1 && ph <= L) begin
        int k;
        logic [7:0] em;
        k  = (ph - 1) / (S0 + 1);
        em = tt_of(mode) & 8'((1 << k) - 1);
        chk("m_busy", int'(busy0), 1);
        chk("m_done", int'(done0), 0);
        chk("m_din", int'(dut_in0), k);
        chk("m_min", int'(min0), int'(em));
        chk("m_ones", int'(ones0), $countones(em));
      end else begin
        chk("m_busy", int'(busy0), 0);
        chk("m_done", int'(done0), (ph == L + 1) ? 1 : 0);
        chk("m_din", int'(dut_in0), mdin);
        chk("m_min", int'(min0), int'(mmin));
        chk("m_ones", int'(ones0), mones);
      end
      chk("m_match", int'(match0), int'(mmatch));
      chk("m_ff", int'(ff0), mff);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(int id, logic [7:0] e);
    @(negedge clk);
    case (id)
      0: begin expected0 = e; start0 = 1'b1; end
      1: begin expected1 = e; start1 = 1'b1; end
      default: begin expected2 = e; start2 = 1'b1; end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  function automatic logic done_of(int id);
    return (id == 0) ? done0 : (id == 1) ? done1 : done2;
  endfunction

  task automatic wait_done(int id, output int c);
    c = 0;
    while (!done_of(id) && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!done_of(id)) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    start0 = 0; start1 = 0; start2 = 0;
    expected0 = '0; expected1 = '0; expected2 = '0;
    tick(3);
    chk("rst_min", int'(min0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_din", int'(dut_in0), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(2);

    pulse(0, 8'hCD);
    wait_done(0, c);
    chk("t1_lat", c, 16);
    chk("t1_min", int'(min0), 8'hCD);
    chk("t1_ones", int'(ones0), 5);
    chk("t1_match", int'(match0), 1);
    chk("t1_ff", int'(ff0), 0);
    tick(1);
    chk("t1_pulse", int'(done0), 0);
    tick(2);

    pulse(0, 8'hCF);
    expected0 = 8'hCD;
    wait_done(0, c);
    chk("t2_min", int'(min0), 8'hCD);
    chk("t2_match", int'(match0), 0);
    chk("t2_ff", int'(ff0), 1);
    tick(3);

    pulse(1, 8'hCD);
    wait_done(1, c);
    chk("t3_lat", c, 32);
    chk("t3_min", int'(min1), 8'hCD);
    chk("t3_match", int'(match1), 1);
    pulse(2, 8'hCD);
    wait_done(2, c);
    chk("t3_fast_match", int'(match2), 0);
    tick(3);

    pulse(0, 8'hCD);
    tick(4);
    start0 = 1'b1;
    expected0 = 8'h00;
    tick(1);
    start0 = 1'b0;
    tick(4);
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    wait_done(0, c);
    chk("t4_lat", c, 6);
    chk("t4_min", int'(min0), 8'hCD);
    chk("t4_match", int'(match0), 1);
    tick(5);

    pulse(0, 8'hCD);
    tick(6);
    reset = 1'b1;
    tick(1);
    chk("t5_busy", int'(busy0), 0);
    chk("t5_min", int'(min0), 0);
    chk("t5_din", int'(dut_in0), 0);
    chk("t5_done", int'(done0), 0);
    reset = 1'b0;
    tick(2);
    pulse(0, 8'hCD);
    wait_done(0, c);
    chk("t5_lat", c, 16);
    chk("t5_match", int'(match0), 1);
    tick(2);

    mode = 1;
    pulse(0, 8'hFF);
    wait_done(0, c);
    chk("t6_min1", int'(min0), 8'hFF);
    chk("t6_ones1", int'(ones0), 8);
    tick(2);
    mode = 2;
    pulse(0, 8'h00);
    wait_done(0, c);
    chk("t6_min0", int'(min0), 0);
    chk("t6_ones0", int'(ones0), 0);
    chk("t6_match0", int'(match0), 1);
    tick(2);

    mode = 0;
    expected0 = 8'hCD;
    start0 = 1'b1;
    wait_done(0, c);
    for (int r = 0; r < 2; r++) begin
      tick(1);
      wait_done(0, c);
      chk("b2b_period", c + 1, 18);
    end
    start0 = 1'b0;
    c = 0;
    while ((busy0 || done0) && c < 100) begin
      tick(1);
      c++;
    end
    chk("b2b_idle", int'(busy0), 0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
